io_readback: RTL and testbench

- Reader side of the GPIO serial register path: on a host readback request, snapshots the four 16-bit GPIO pin banks and returns a 32-bit word.
- The word appears both as a parallel value and as a bit-serial stream, MSB first, on the readback line.
- Sits beside the GPIO output-enable write logic, fed by the same serial address/strobe decoder, and drives the serial readback path toward the host.

---
 rtl/io_readback_pkg.sv | 22 ++
 rtl/io_readback_sync_2ff.sv | 32 +++
 rtl/io_readback.sv | 163 ++++++++++++++++
 tb/tb_io_readback.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/io_readback_pkg.sv
// rtl/io_readback_pkg.sv - shared constants and FSM encoding for io_readback
//
// Contents: default readback addresses, word/bank widths, bit-counter width,
// and the two-state shifter FSM encoding.
package io_readback_pkg;

    localparam int WORD_W = 32;
    localparam int BANK_W = 16;
    localparam int IO_W   = 4 * BANK_W;
    localparam int CNT_W  = $clog2(WORD_W);

    localparam logic [6:0] DEF_RB_ADDR_01    = 7'd1;
    localparam logic [6:0] DEF_RB_ADDR_23    = 7'd2;
    localparam logic [6:0] DEF_RB_ADDR_CHG01 = 7'd3;
    localparam logic [6:0] DEF_RB_ADDR_CHG23 = 7'd4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/io_readback_sync_2ff.sv
// rtl/io_readback_sync_2ff.sv - parameterized-width two-flop synchronizer
//
// Ports:
//   clock  in   system clock
//   reset  in   synchronous, active-high; clears both stages
//   i_d    in   asynchronous input bits (WIDTH)
//   o_q    out  second-stage synchronized bits (WIDTH)
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= i_d;
            r_sync2 <= r_sync1;
        end
    end

    assign o_q = r_sync2;

endmodule

// File: rtl/io_readback.sv
// rtl/io_readback.sv - GPIO bank snapshot with parallel and MSB-first serial readback
//
// Optional feature macro: IO_READBACK_EDGE_EN (sticky per-pin change flags,
// readable at RB_ADDR_CHG01 / RB_ADDR_CHG23 and cleared by that read).
//
// Ports:
//   clock, reset       system clock; synchronous active-high reset
//   io_0..io_3         16-bit asynchronous pin banks
//   rd_addr, rd_strobe readback request (address valid with strobe)
//   shift_en           host has sampled the current sdo bit
//   sdo                serial readback bit, MSB first
//   busy               word shift in progress
//   rd_valid           one-cycle pulse when rd_data updates
//   rd_data            last captured word
//   overrun            sticky: request arrived while busy
module io_readback
    import io_readback_pkg::*;
#(
    parameter logic [6:0] RB_ADDR_01    = DEF_RB_ADDR_01,
    parameter logic [6:0] RB_ADDR_23    = DEF_RB_ADDR_23,
    parameter logic [6:0] RB_ADDR_CHG01 = DEF_RB_ADDR_CHG01,
    parameter logic [6:0] RB_ADDR_CHG23 = DEF_RB_ADDR_CHG23
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [BANK_W-1:0] io_0,
    input  logic [BANK_W-1:0] io_1,
    input  logic [BANK_W-1:0] io_2,
    input  logic [BANK_W-1:0] io_3,
    input  logic [6:0]        rd_addr,
    input  logic              rd_strobe,
    input  logic              shift_en,
    output logic              sdo,
    output logic              busy,
    output logic              rd_valid,
    output logic [WORD_W-1:0] rd_data,
    output logic              overrun
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_W - 1);

    logic [IO_W-1:0]   w_sync2;
    logic [WORD_W-1:0] w_mux_word;
    logic              w_accept;

    state_t            r_state,    w_state_nxt;
    logic [WORD_W-1:0] r_shift,    w_shift_nxt;
    logic [CNT_W-1:0]  r_cnt,      w_cnt_nxt;
    logic [WORD_W-1:0] r_rd_data,  w_rd_data_nxt;
    logic              r_rd_valid, w_rd_valid_nxt;
    logic              r_overrun,  w_overrun_nxt;

    sync_2ff #(.WIDTH(IO_W)) u_sync (
        .clock (clock),
        .reset (reset),
        .i_d   ({io_3, io_2, io_1, io_0}),
        .o_q   (w_sync2)
    );

    assign w_accept = (r_state == ST_IDLE) && rd_strobe;

`ifdef IO_READBACK_EDGE_EN
    logic [IO_W-1:0] r_chg;
    logic [IO_W-1:0] r_sync2_prev;
    logic [IO_W-1:0] w_chg_clr;

    always_comb begin
        w_chg_clr = '0;
        if (w_accept && rd_addr == RB_ADDR_CHG01) begin
            w_chg_clr[WORD_W-1:0] = '1;
        end else if (w_accept && rd_addr == RB_ADDR_CHG23) begin
            w_chg_clr[IO_W-1:WORD_W] = '1;
        end
    end

    // Set term is OR-ed after the clear so a change landing on the
    // clearing read is kept for the next read.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_chg        <= '0;
            r_sync2_prev <= '0;
        end else begin
            r_sync2_prev <= w_sync2;
            r_chg        <= (r_chg & ~w_chg_clr) | (w_sync2 ^ r_sync2_prev);
        end
    end
`endif

    always_comb begin
        w_mux_word = '0;
        case (rd_addr)
            RB_ADDR_01:    w_mux_word = w_sync2[WORD_W-1:0];
            RB_ADDR_23:    w_mux_word = w_sync2[IO_W-1:WORD_W];
`ifdef IO_READBACK_EDGE_EN
            RB_ADDR_CHG01: w_mux_word = r_chg[WORD_W-1:0];
            RB_ADDR_CHG23: w_mux_word = r_chg[IO_W-1:WORD_W];
`else
            RB_ADDR_CHG01: w_mux_word = '0;
            RB_ADDR_CHG23: w_mux_word = '0;
`endif
            default:       w_mux_word = '0;
        endcase
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_shift_nxt    = r_shift;
        w_cnt_nxt      = r_cnt;
        w_rd_data_nxt  = r_rd_data;
        w_rd_valid_nxt = 1'b0;
        // Any strobe seen while shifting is dropped but remembered.
        w_overrun_nxt  = r_overrun | (rd_strobe && r_state == ST_SHIFT);
        case (r_state)
            ST_IDLE: begin
                if (rd_strobe) begin
                    w_state_nxt    = ST_SHIFT;
                    w_shift_nxt    = w_mux_word;
                    w_cnt_nxt      = CNT_LAST;
                    w_rd_data_nxt  = w_mux_word;
                    w_rd_valid_nxt = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (shift_en) begin
                    if (r_cnt != '0) begin
                        w_shift_nxt = {r_shift[WORD_W-2:0], 1'b0};
                        w_cnt_nxt   = r_cnt - CNT_W'(1);
                    end else begin
                        // Clearing the shifter keeps sdo low while idle.
                        w_state_nxt = ST_IDLE;
                        w_shift_nxt = '0;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_shift    <= '0;
            r_cnt      <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_shift    <= w_shift_nxt;
            r_cnt      <= w_cnt_nxt;
            r_rd_data  <= w_rd_data_nxt;
            r_rd_valid <= w_rd_valid_nxt;
            r_overrun  <= w_overrun_nxt;
        end
    end

    assign sdo      = r_shift[WORD_W-1];
    assign busy     = (r_state == ST_SHIFT);
    assign rd_valid = r_rd_valid;
    assign rd_data  = r_rd_data;
    assign overrun  = r_overrun;

endmodule

// File: tb/tb_io_readback.sv
// tb/tb_io_readback.sv - self-checking bench for io_readback
module tb_io_readback;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] io_0, io_1, io_2, io_3;
    logic [6:0]  rd_addr;
    logic        rd_strobe;
    logic        shift_en;
    logic        sdo;
    logic        busy;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        overrun;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: pin values already propagated and sticky change flags.
    logic [63:0] prev_m;
    logic [63:0] chg_m;

    io_readback dut (
        .clock     (clock),
        .reset     (reset),
        .io_0      (io_0),
        .io_1      (io_1),
        .io_2      (io_2),
        .io_3      (io_3),
        .rd_addr   (rd_addr),
        .rd_strobe (rd_strobe),
        .shift_en  (shift_en),
        .sdo       (sdo),
        .busy      (busy),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .overrun   (overrun)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_io(input logic [15:0] a0, input logic [15:0] a1,
                          input logic [15:0] a2, input logic [15:0] a3);
        io_0 = a0; io_1 = a1; io_2 = a2; io_3 = a3;
        chg_m  = chg_m | (prev_m ^ {a3, a2, a1, a0});
        prev_m = {a3, a2, a1, a0};
    endtask

    // After reset the synchronized pins rise from zero to the current pins.
    task automatic model_reset();
        chg_m  = {io_3, io_2, io_1, io_0};
        prev_m = {io_3, io_2, io_1, io_0};
    endtask

    task automatic model_read(input logic [6:0] a, output logic [31:0] w);
        case (a)
            7'd1: w = {io_1, io_0};
            7'd2: w = {io_3, io_2};
`ifdef IO_READBACK_EDGE_EN
            7'd3: begin w = chg_m[31:0];  chg_m[31:0]  = '0; end
            7'd4: begin w = chg_m[63:32]; chg_m[63:32] = '0; end
`endif
            default: w = 32'h0;
        endcase
    endtask

    task automatic do_read(input logic [6:0] a, input logic [31:0] exp, input logic with_shift);
        rd_addr = a; rd_strobe = 1'b1; shift_en = with_shift;
        tick();
        rd_strobe = 1'b0; shift_en = 1'b0;
        chk("rd_valid", rd_valid, 1);
        chk("rd_data", rd_data, exp);
        chk("busy_start", busy, 1);
        chk("sdo_msb", sdo, exp[31]);
        tick();
        chk("rd_valid_pulse", rd_valid, 0);
        chk("sdo_hold", sdo, exp[31]);
    endtask

    task automatic shift_word(input logic [31:0] exp, input logic ovr, input int gap_max);
        for (int k = 0; k < 32; k++) begin
            chk("sdo_bit", sdo, exp[31-k]);
            shift_en = 1'b1;
            if (ovr && (k == 10 || k == 31)) begin
                rd_strobe = 1'b1;
                rd_addr   = 7'd2;
            end
            tick();
            shift_en = 1'b0; rd_strobe = 1'b0;
            chk("no_valid_in_shift", rd_valid, 0);
            if (ovr && k >= 10) chk("overrun_set", overrun, 1);
            if (k < 31) begin
                chk("busy_mid", busy, 1);
                repeat ($urandom_range(0, gap_max)) tick();
            end
        end
        chk("busy_end", busy, 0);
        chk("sdo_end", sdo, 0);
        chk("rd_data_held", rd_data, exp);
    endtask

    initial begin
        logic [31:0] w;
        logic [6:0]  a;

        reset = 1'b1; rd_strobe = 1'b0; shift_en = 1'b0; rd_addr = '0;
        io_0 = '0; io_1 = '0; io_2 = '0; io_3 = '0;
        prev_m = '0; chg_m = '0;
        tick(); tick();
        chk("rst_sdo", sdo, 0);
        chk("rst_busy", busy, 0);
        chk("rst_valid", rd_valid, 0);
        chk("rst_data", rd_data, 0);
        chk("rst_overrun", overrun, 0);
        reset = 1'b0;
        model_reset();

        shift_en = 1'b1;
        tick();
        shift_en = 1'b0;
        chk("idle_shift_busy", busy, 0);
        chk("idle_shift_sdo", sdo, 0);

        // basic read of banks 0/1
        set_io(16'h0F0F, 16'hA5C3, 16'h0000, 16'h0000);
        repeat (3) tick();
        do_read(7'd1, 32'hA5C3_0F0F, 1'b0);
        shift_word(32'hA5C3_0F0F, 1'b0, 2);

        // banks 2/3 (strobe coincident with shift_en), then unknown address
        set_io(16'h0F0F, 16'hA5C3, 16'h5678, 16'h1234);
        repeat (3) tick();
        do_read(7'd2, 32'h1234_5678, 1'b1);
        shift_word(32'h1234_5678, 1'b0, 1);
        do_read(7'd9, 32'h0, 1'b0);
        shift_word(32'h0, 1'b0, 1);

        // overrun at bit 10 and at the final shift_en
        do_read(7'd1, 32'hA5C3_0F0F, 1'b0);
        shift_word(32'hA5C3_0F0F, 1'b1, 1);
        tick();
        chk("overrun_sticky", overrun, 1);
        chk("overrun_no_accept", busy, 0);

        // reset in the middle of a word
        do_read(7'd2, 32'h1234_5678, 1'b0);
        for (int k = 0; k < 5; k++) begin
            chk("pre_rst_bit", sdo, w_bit(32'h1234_5678, k));
            shift_en = 1'b1;
            tick();
            shift_en = 1'b0;
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_reset();
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_sdo", sdo, 0);
        chk("mid_rst_data", rd_data, 0);
        chk("mid_rst_overrun", overrun, 0);
        chk("mid_rst_valid", rd_valid, 0);
        repeat (3) tick();
        chk("post_rst_idle_sdo", sdo, 0);
        do_read(7'd1, 32'hA5C3_0F0F, 1'b0);
        shift_word(32'hA5C3_0F0F, 1'b0, 0);

        // two-cycle synchronizer latency
        set_io(16'h0000, 16'h8001, io_2, io_3);
        repeat (3) tick();
        set_io(16'hFFFF, 16'h8001, io_2, io_3);
        tick();
        do_read(7'd1, 32'h8001_0000, 1'b0);
        shift_word(32'h8001_0000, 1'b0, 0);
        set_io(16'h0000, 16'h8001, io_2, io_3);
        repeat (3) tick();
        set_io(16'hFFFF, 16'h8001, io_2, io_3);
        tick(); tick();
        do_read(7'd1, 32'h8001_FFFF, 1'b0);
        shift_word(32'h8001_FFFF, 1'b0, 0);

`ifdef IO_READBACK_EDGE_EN
        model_read(7'd3, w); do_read(7'd3, w, 1'b0); shift_word(w, 1'b0, 0);
        model_read(7'd4, w); do_read(7'd4, w, 1'b0); shift_word(w, 1'b0, 0);
        set_io(io_0, io_1, io_2 ^ 16'h0001, io_3);
        repeat (3) tick();
        do_read(7'd4, 32'h0000_0001, 1'b0);
        chg_m[63:32] = '0;
        shift_word(32'h0000_0001, 1'b0, 0);
        do_read(7'd4, 32'h0, 1'b0);
        shift_word(32'h0, 1'b0, 0);
        // toggle lands in the change register on the clearing read cycle
        set_io(io_0, io_1, io_2 ^ 16'h0001, io_3);
        tick(); tick();
        do_read(7'd4, 32'h0, 1'b0);
        shift_word(32'h0, 1'b0, 0);
        do_read(7'd4, 32'h0000_0001, 1'b0);
        chg_m[63:32] = '0;
        shift_word(32'h0000_0001, 1'b0, 0);
`else
        do_read(7'd3, 32'h0, 1'b0); shift_word(32'h0, 1'b0, 0);
        do_read(7'd4, 32'h0, 1'b0); shift_word(32'h0, 1'b0, 0);
`endif

        // randomized reads against the reference model
        for (int i = 0; i < 16; i++) begin
            set_io(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
            repeat (3) tick();
            case ($urandom_range(0, 5))
                0:       a = 7'd1;
                1:       a = 7'd2;
                2:       a = 7'd3;
                3:       a = 7'd4;
                default: a = 7'($urandom);
            endcase
            model_read(a, w);
            do_read(a, w, 1'($urandom_range(0, 1)));
            shift_word(w, 1'b0, 3);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    function automatic logic w_bit(input logic [31:0] word, input int k);
        return word[31-k];
    endfunction

endmodule
